muldiv_unit: RTL and testbench

//   Multi-cycle multiply/divide/remainder unit; the iterative counterpart of the

---
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative unsigned multiply / divide / remainder unit. It pairs with the
//   single-cycle datapath ALU and uses the same Control encoding, so one decoder
//   drives both units. Requests come in over a valid/ready channel. Each
//   operation takes WIDTH step cycles: one shift-add per cycle for MUL, or one
//   restoring subtract per cycle for DIV/REM. The result is held on a
//   valid/ready response channel until the consumer takes it.
//
// Ports
//   Clk       in   1      clock, rising edge
//   Reset     in   1      synchronous, active-high reset
//   In1       in   WIDTH  operand A (multiplicand / dividend)
//   In2       in   WIDTH  operand B (multiplier / divisor)
//   Control   in   4      2 = MUL, 3 = DIV, 4 = REM, any other code returns 0
//   InValid   in   1      request valid
//   InReady   out  1      unit is idle and can accept a request
//   Out       out  WIDTH  result, held until the next completion
//   OutValid  out  1      result valid
//   OutReady  in   1      consumer accepts the result
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [3:0]       Control,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Out,
  output logic             OutValid,
  input  logic             OutReady
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_REM, OP_NONE} op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc: product accumulator (MUL) or partial remainder (DIV/REM).
  // shf: multiplier, shifted right (MUL), or dividend shifting out while the
  //      quotient shifts in (DIV/REM).
  // opa: multiplicand, shifted left (MUL), or divisor (DIV/REM).
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] out_q, out_d;

  // Restoring-division step terms. The partial remainder is always smaller than
  // the divisor, so whenever the subtraction is taken its result fits in WIDTH
  // bits. A zero divisor therefore always subtracts, which gives a quotient of
  // all ones and a remainder equal to the dividend.
  logic [WIDTH:0]   rem_shift;
  logic             take;
  logic [WIDTH-1:0] rem_sub;

  assign rem_shift = {acc_q, shf_q[WIDTH-1]};
  assign take      = (rem_shift >= {1'b0, opa_q});
  assign rem_sub   = rem_shift[WIDTH-1:0] - opa_q;

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    shf_d   = shf_q;
    opa_d   = opa_q;
    out_d   = out_q;

    unique case (state_q)
      S_IDLE: begin
        if (InValid) begin
          unique case (Control)
            4'd2:    op_d = OP_MUL;
            4'd3:    op_d = OP_DIV;
            4'd4:    op_d = OP_REM;
            default: op_d = OP_NONE;
          endcase
          cnt_d   = '0;
          acc_d   = '0;
          shf_d   = (Control == 4'd2) ? In2 : In1;
          opa_d   = (Control == 4'd2) ? In1 : In2;
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        unique case (op_q)
          OP_MUL: begin
            acc_d = acc_q + (shf_q[0] ? opa_q : '0);
            opa_d = opa_q << 1;
            shf_d = shf_q >> 1;
          end
          OP_DIV, OP_REM: begin
            acc_d = take ? rem_sub : rem_shift[WIDTH-1:0];
            shf_d = {shf_q[WIDTH-2:0], take};
          end
          default: ;  // unsupported op only burns the same number of cycles
        endcase
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          unique case (op_q)
            OP_MUL:  out_d = acc_d;
            OP_DIV:  out_d = shf_d;
            OP_REM:  out_d = acc_d;
            default: out_d = '0;
          endcase
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (OutReady) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples the values from before the edge, whatever order the lines are in.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      shf_q   <= '0;
      opa_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      shf_q   <= shf_d;
      opa_q   <= opa_d;
      out_q   <= out_d;
    end
  end

  assign InReady  = (state_q == S_IDLE);
  assign OutValid = (state_q == S_DONE);
  assign Out      = out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed, self-checking bench for muldiv_unit (WIDTH = 32). Inputs are
//   driven and outputs sampled 1 ns after each rising edge. Every expected value
//   is a hand-computed constant.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int WIDTH = 32;
  localparam logic [3:0] C_MUL = 4'd2;
  localparam logic [3:0] C_DIV = 4'd3;
  localparam logic [3:0] C_REM = 4'd4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in1, in2;
  logic [3:0]       control;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .Clk      (clk),
    .Reset    (reset),
    .In1      (in1),
    .In2      (in2),
    .Control  (control),
    .InValid  (in_valid),
    .InReady  (in_ready),
    .Out      (out),
    .OutValid (out_valid),
    .OutReady (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for InReady, presents a request and lets one edge accept it.
  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] ctl, input bit hold);
    int waited = 0;
    while (!in_ready && waited < 100) begin
      tick();
      waited++;
    end
    check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    in1      = a;
    in2      = b;
    control  = ctl;
    in_valid = 1'b1;
    tick();
    if (!hold) in_valid = 1'b0;
  endtask

  // Runs the WIDTH cycles that follow the accept edge. OutValid must stay low
  // until the WIDTH-th edge and InReady must stay low throughout.
  task automatic wait_result(input string tag, input logic [31:0] exp, input bit scramble);
    bit early = 1'b0;
    bit ready_busy = 1'b0;
    for (int i = 1; i <= WIDTH; i++) begin
      if (scramble) begin
        in1     = $urandom;
        in2     = $urandom;
        control = 4'($urandom_range(0, 15));
      end
      tick();
      if (i < WIDTH) begin
        if (out_valid) early = 1'b1;
        if (in_ready)  ready_busy = 1'b1;
      end
    end
    check({tag, "_early_valid"}, 32'(early), 32'd0);
    check({tag, "_ready_busy"}, 32'(ready_busy), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_out"}, out, exp);
  endtask

  task automatic handshake(input string tag, input logic [31:0] exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_hs_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_hs_hold"}, out, exp);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] ctl, input logic [31:0] exp);
    issue(tag, a, b, ctl, 1'b0);
    wait_result(tag, exp, 1'b0);
    handshake(tag, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    reset     = 1'b1;
    in1       = '0;
    in2       = '0;
    control   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out", out, 32'd0);

    // Multiply.
    run_op("mul_7x6", 32'd7, 32'd6, C_MUL, 32'd42);
    run_op("mul_max_x2", 32'hFFFF_FFFF, 32'd2, C_MUL, 32'hFFFF_FFFE);

    // Divide and remainder.
    run_op("div_100_7", 32'd100, 32'd7, C_DIV, 32'd14);
    run_op("rem_100_7", 32'd100, 32'd7, C_REM, 32'd2);
    run_op("div_5_9", 32'd5, 32'd9, C_DIV, 32'd0);
    run_op("rem_5_9", 32'd5, 32'd9, C_REM, 32'd5);

    // Divide by zero and unsupported codes.
    run_op("div_by0", 32'd1234, 32'd0, C_DIV, 32'hFFFF_FFFF);
    run_op("rem_by0", 32'd1234, 32'd0, C_REM, 32'd1234);
    run_op("ctl0", 32'd5, 32'd3, 4'd0, 32'd0);
    run_op("ctl15", 32'hDEAD_BEEF, 32'd3, 4'd15, 32'd0);

    // Backpressure: DONE is held for 10 cycles with no change on the outputs.
    issue("bp", 32'd1000, 32'd10, C_DIV, 1'b0);
    wait_result("bp", 32'd100, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!out_valid || out !== 32'd100 || in_ready) bad = 1'b1;
    end
    check("bp_stable", 32'(bad), 32'd0);
    handshake("bp", 32'd100);

    // Inputs change every busy cycle while InValid stays high. The held request
    // must not be taken in the handshake cycle, only on the following edge.
    issue("scr", 32'd7, 32'd6, C_MUL, 1'b1);
    wait_result("scr_mul", 32'd42, 1'b1);
    in1     = 32'd100;
    in2     = 32'd7;
    control = C_DIV;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("scr_idle_ready", 32'(in_ready), 32'd1);
    check("scr_idle_out", out, 32'd42);
    tick();
    in_valid = 1'b0;
    check("scr_taken", 32'(in_ready), 32'd0);
    wait_result("scr_div", 32'd14, 1'b0);
    handshake("scr_div", 32'd14);

    // Reset in the middle of an operation, when the iteration counter is 15.
    issue("mid_rst", 32'd3, 32'd5, C_MUL, 1'b0);
    repeat (15) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out", out, 32'd0);
    run_op("div_9_3", 32'd9, 32'd3, C_DIV, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
